// File: rtl/profile_ci_pkg.sv
// profile_ci_pkg
//   Shared constants for the profiling custom instruction: opcode values
//   carried in valueA[3:0] and the hardware ceiling on counter channels.
package profile_ci_pkg;

    localparam int MAX_COUNTERS = 8;

    localparam logic [3:0] OP_READ_LO  = 4'd0;
    localparam logic [3:0] OP_READ_HI  = 4'd1;
    localparam logic [3:0] OP_CONTROL  = 4'd2;
    localparam logic [3:0] OP_SELECT   = 4'd3;
    localparam logic [3:0] OP_SNAPSHOT = 4'd4;
    localparam logic [3:0] OP_STATUS   = 4'd5;

endpackage

// File: rtl/event_counter.sv
// event_counter
//   One profiling channel: a free-running up-counter that advances once per
//   cycle in which it is enabled and its selected event is present.
//   Ports:
//     clock  - rising-edge clock
//     reset  - synchronous active-low reset
//     enable - channel enable (registered in the parent)
//     evt    - selected event qualifier for this cycle
//     clear  - force the count to zero on this edge (wins over counting)
//     value  - current count
//     wrap   - high in the cycle whose edge takes the count from all-ones to 0
module event_counter #(
    parameter int WIDTH = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             evt,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] count;
    logic             bump;

    assign bump  = enable && evt;
    // A clear on the same edge means the count never actually wraps.
    assign wrap  = bump && !clear && (count == '1);
    assign value = count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (bump) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/profile_ci_multi.sv
// profile_ci_multi
//   Multi-channel performance-counter custom instruction. A command is taken
//   when start=1 and ciN matches customId; done pulses one cycle later with
//   the result (result is 0 whenever done is 0).
//   Ports:
//     clock, reset    - rising-edge clock, synchronous active-low reset
//     start, ciN      - CI strobe and CI number
//     valueA          - [3:0] opcode, [4] read the shadow copy instead of live
//     valueB          - operand (channel index / masks / event select)
//     events          - per-cycle event qualifiers
//     done, result    - registered completion pulse and returned data
module profile_ci_multi
    import profile_ci_pkg::*;
#(
    parameter logic [7:0] customId      = 8'd8,
    parameter int         NB_COUNTERS   = 8,
    parameter int         NB_EVENTS     = 8,
    parameter int         COUNTER_WIDTH = 48
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           ciN,
    input  logic [31:0]          valueA,
    input  logic [31:0]          valueB,
    input  logic [NB_EVENTS-1:0] events,
    output logic                 done,
    output logic [31:0]          result
);

    localparam logic [MAX_COUNTERS-1:0] CH_MASK = MAX_COUNTERS'((1 << NB_COUNTERS) - 1);

    logic                     accept;
    logic [3:0]               opcode;
    logic [2:0]               ch;
    logic                     ch_ok;
    logic [MAX_COUNTERS-1:0]  enable_q, overflow_q;
    logic [MAX_COUNTERS-1:0]  hit_v, wrap_v, clear_v, set_mask, dis_mask, ov_clr;
    logic [7:0]               sel_q  [MAX_COUNTERS];
    logic [COUNTER_WIDTH-1:0] live   [MAX_COUNTERS];
    logic [COUNTER_WIDTH-1:0] shadow_q [MAX_COUNTERS];
    logic [255:0]             ev_pad;
    logic [63:0]              sel_ext;
    logic [31:0]              result_next;
    logic                     unused_bits;

    assign accept = start && (ciN == customId);
    assign opcode = valueA[3:0];
    assign ch     = valueB[2:0];
    assign ch_ok  = int'({29'd0, ch}) < NB_COUNTERS;

    // Padding the event vector to 256 bits makes any select index beyond
    // NB_EVENTS read a constant 0, so such a channel never counts.
    assign ev_pad = 256'(events);

    assign set_mask = (accept && opcode == OP_CONTROL) ? (valueB[7:0]   & CH_MASK) : '0;
    assign dis_mask = (accept && opcode == OP_CONTROL) ? (valueB[15:8]  & CH_MASK) : '0;
    assign clear_v  = (accept && opcode == OP_CONTROL) ? (valueB[23:16] & CH_MASK) : '0;
    assign ov_clr   = (accept && opcode == OP_STATUS)  ? (valueB[7:0]   & CH_MASK) : '0;

    for (genvar i = 0; i < MAX_COUNTERS; i++) begin : g_ch
        if (i < NB_COUNTERS) begin : g_live
            assign hit_v[i] = ev_pad[sel_q[i]];
            event_counter #(.WIDTH(COUNTER_WIDTH)) u_counter (
                .clock  (clock),
                .reset  (reset),
                .enable (enable_q[i]),
                .evt    (hit_v[i]),
                .clear  (clear_v[i]),
                .value  (live[i]),
                .wrap   (wrap_v[i])
            );
        end else begin : g_tie
            assign hit_v[i]  = 1'b0;
            assign live[i]   = '0;
            assign wrap_v[i] = 1'b0;
        end
    end

    // Reads see the pre-edge counter/shadow values.
    assign sel_ext = 64'(valueA[4] ? shadow_q[ch] : live[ch]);

    always_comb begin
        result_next = '0;
        if (accept) begin
            case (opcode)
                OP_READ_LO: if (ch_ok) result_next = sel_ext[31:0];
                OP_READ_HI: if (ch_ok) result_next = sel_ext[63:32];
                OP_STATUS:  result_next = {16'b0, overflow_q, enable_q};
                default:    result_next = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            done       <= 1'b0;
            result     <= '0;
            enable_q   <= '0;
            overflow_q <= '0;
            for (int i = 0; i < MAX_COUNTERS; i++) begin
                sel_q[i]    <= 8'(i % NB_EVENTS);
                shadow_q[i] <= '0;
            end
        end else begin
            done       <= accept;
            result     <= result_next;
            // Disable beats enable-set; a fresh wrap beats an overflow clear.
            enable_q   <= (enable_q | set_mask) & ~dis_mask;
            overflow_q <= (overflow_q & ~ov_clr) | wrap_v;
            if (accept && opcode == OP_SELECT && ch_ok) begin
                sel_q[ch] <= valueB[15:8];
            end
            if (accept && opcode == OP_SNAPSHOT) begin
                for (int i = 0; i < MAX_COUNTERS; i++) begin
                    shadow_q[i] <= live[i];
                end
            end
        end
    end

    assign unused_bits = ^{valueA[31:5], valueB[31:24]};

endmodule

// File: tb/tb_profile_ci_multi.sv
module tb_profile_ci_multi;

    localparam logic [7:0] CID = 8'd8;
    localparam int NC = 8;
    localparam int NE = 8;
    localparam int W  = 48;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    ciN = '0;
    logic [31:0]   valueA = '0;
    logic [31:0]   valueB = '0;
    logic [NE-1:0] events = '0;
    logic          done;
    logic [31:0]   result;

    int n_checks = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0]  m_cnt [NC];
    logic [W-1:0]  m_sh  [NC];
    logic [7:0]    m_sel [NC];
    logic [NC-1:0] m_en, m_ov;
    logic          e_done;
    logic [31:0]   e_res;
    logic [31:0]   last_res;

    profile_ci_multi #(
        .customId(CID), .NB_COUNTERS(NC), .NB_EVENTS(NE), .COUNTER_WIDTH(W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .events(events),
        .done(done), .result(result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the effect of the currently driven inputs, let the
    // edge happen, then compare done/result just after it.
    task automatic tick();
        logic         acc;
        logic [3:0]   op;
        logic [2:0]   ch;
        logic [31:0]  r;
        logic [63:0]  v;
        logic [NC-1:0] wr;
        logic [W-1:0] pre [NC];
        logic         ev;
        acc = start && (ciN == CID);
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                m_cnt[i] = '0;
                m_sh[i]  = '0;
                m_sel[i] = 8'(i % NE);
            end
            m_en = '0;
            m_ov = '0;
            e_done = 1'b0;
            e_res  = '0;
        end else begin
            op = valueA[3:0];
            ch = valueB[2:0];
            r  = '0;
            wr = '0;
            for (int i = 0; i < NC; i++) pre[i] = m_cnt[i];
            if (acc) begin
                v = valueA[4] ? 64'(m_sh[ch]) : 64'(m_cnt[ch]);
                if (op == 4'd0) r = v[31:0];
                else if (op == 4'd1) r = v[63:32];
                else if (op == 4'd5) r = {16'b0, m_ov, m_en};
            end
            for (int i = 0; i < NC; i++) begin
                ev = (m_sel[i] < NE) ? events[m_sel[i][2:0]] : 1'b0;
                if (m_en[i] && ev) begin
                    if (m_cnt[i] == {W{1'b1}}) begin
                        m_cnt[i] = '0;
                        wr[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            if (acc) begin
                case (op)
                    4'd2: begin
                        for (int i = 0; i < NC; i++) begin
                            if (valueB[16+i]) begin
                                m_cnt[i] = '0;
                                wr[i] = 1'b0;
                            end
                        end
                        m_en = (m_en | valueB[7:0]) & ~valueB[15:8];
                    end
                    4'd3: m_sel[ch] = valueB[15:8];
                    4'd4: for (int i = 0; i < NC; i++) m_sh[i] = pre[i];
                    4'd5: m_ov = m_ov & ~valueB[7:0];
                    default: ;
                endcase
            end
            m_ov = m_ov | wr;
            e_done = acc;
            e_res  = r;
        end
        @(posedge clock);
        #1;
        check("done", 64'(done), 64'(e_done));
        check("result", 64'(result), 64'(e_res));
        last_res = result;
    endtask

    // Randomize the event vector, forcing the bits in mask to val.
    task automatic set_ev(input logic [7:0] mask, input logic [7:0] val);
        events = (8'($urandom) & ~mask) | (val & mask);
    endtask

    task automatic run(input int n, input logic [7:0] mask, input logic [7:0] val);
        for (int k = 0; k < n; k++) begin
            set_ev(mask, val);
            tick();
        end
    endtask

    task automatic cmd(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        ciN = CID;
        valueA = a;
        valueB = b;
        tick();
        start = 1'b0;
        valueA = '0;
        valueB = '0;
    endtask

    initial begin
        // Reset and idle state
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        cmd(32'h5, 32'h0);
        check("reset_status", 64'(last_res), 64'h0);
        cmd(32'h0, 32'h3);
        check("reset_read_ch3", 64'(last_res), 64'h0);

        // Channel 0 counts CPU cycles for 100 cycles
        set_ev(8'h01, 8'h01);
        cmd(32'h2, 32'h000001);
        run(100, 8'h01, 8'h01);
        cmd(32'h0, 32'h0);
        check("ch0_count_100", 64'(last_res), 64'd100);
        tick();
        check("done_one_cycle", 64'(done), 64'h0);

        // Channel 1 counts exactly 37 stall cycles
        cmd(32'h3, 32'h0101);
        cmd(32'h2, 32'h000002);
        for (int k = 0; k < 37; k++) begin
            run($urandom_range(0, 2), 8'h02, 8'h00);
            run(1, 8'h02, 8'h02);
        end
        set_ev(8'h02, 8'h00);
        cmd(32'h0, 32'h1);
        check("ch1_stall_37", 64'(last_res), 64'd37);

        // Channel 2 wrap: preload all-ones, then one event
        set_ev(8'h04, 8'h00);
        force dut.g_ch[2].g_live.u_counter.count = {W{1'b1}};
        #1;
        release dut.g_ch[2].g_live.u_counter.count;
        m_cnt[2] = {W{1'b1}};
        cmd(32'h1, 32'h2);
        check("ch2_hi_allones", 64'(last_res), 64'hFFFF);
        cmd(32'h2, 32'h000004);
        run(1, 8'h04, 8'h04);
        set_ev(8'h04, 8'h00);
        cmd(32'h0, 32'h2);
        check("ch2_lo_wrapped", 64'(last_res), 64'h0);
        cmd(32'h1, 32'h2);
        check("ch2_hi_wrapped", 64'(last_res), 64'h0);
        cmd(32'h5, 32'h0);
        check("ov2_set", 64'(last_res[10]), 64'h1);
        cmd(32'h5, 32'h04);
        cmd(32'h5, 32'h0);
        check("ov2_cleared", 64'(last_res[10]), 64'h0);

        // Snapshot at 50, live reaches 70
        set_ev(8'h08, 8'h00);
        cmd(32'h2, 32'h080008);
        run(50, 8'h08, 8'h08);
        cmd(32'h4, 32'h0);
        run(19, 8'h08, 8'h08);
        set_ev(8'h08, 8'h00);
        cmd(32'h10, 32'h3);
        check("ch3_shadow_50", 64'(last_res), 64'd50);
        cmd(32'h0, 32'h3);
        check("ch3_live_70", 64'(last_res), 64'd70);

        // Set, disable and clear ch0 together
        run(5, 8'h00, 8'h00);
        cmd(32'h2, 32'h010101);
        run(5, 8'h01, 8'h01);
        cmd(32'h0, 32'h0);
        check("ch0_cleared", 64'(last_res), 64'h0);
        cmd(32'h5, 32'h0);
        check("ch0_disabled", 64'(last_res[0]), 64'h0);

        // Event select beyond the event vector never counts
        cmd(32'h3, 32'h0000C804);
        cmd(32'h2, 32'h000010);
        run(10, 8'hFF, 8'hFF);
        cmd(32'h0, 32'h4);
        check("ch4_sel_oob", 64'(last_res), 64'h0);

        // Undefined opcodes return 0 with a done pulse
        for (int k = 0; k < 4; k++) begin
            cmd({$urandom_range(0, 32'h0FFF_FFFF), 4'($urandom_range(6, 15))}, $urandom);
            check("undef_op_zero", 64'(last_res), 64'h0);
        end

        // Foreign CI number is ignored
        start = 1'b1;
        ciN = CID + 8'd1;
        valueA = 32'h5;
        tick();
        start = 1'b0;
        check("foreign_ci_no_done", 64'(done), 64'h0);

        // Reset mid-count, with a command in the same cycle
        run(10, 8'h00, 8'h00);
        reset = 1'b0;
        start = 1'b1;
        ciN = CID;
        valueA = 32'h5;
        tick();
        check("reset_beats_cmd", 64'(done), 64'h0);
        reset = 1'b1;
        start = 1'b0;
        valueA = '0;
        run(3, 8'h00, 8'h00);
        for (int c = 0; c < NC; c++) begin
            cmd(32'h0, 32'(c));
            check("post_reset_read", 64'(last_res), 64'h0);
        end
        cmd(32'h5, 32'h0);
        check("post_reset_status", 64'(last_res), 64'h0);

        // Random commands and events against the model
        for (int k = 0; k < 400; k++) begin
            set_ev(8'h00, 8'h00);
            start  = ($urandom_range(0, 1) == 1);
            ciN    = ($urandom_range(0, 7) == 0) ? CID + 8'd1 : CID;
            valueA = {27'($urandom), 1'($urandom), 4'($urandom_range(0, 7))};
            valueB = $urandom;
            if (k == 200) reset = 1'b0;
            tick();
            reset = 1'b1;
        end
        start = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/profile_ci_multi.md
PROFILE_CI_MULTI -- requirements
Module: profile_ci_multi

Interface
REQ-001 SHALL have parameter customId, default 8'd8, the CI number this block answers to.
REQ-002 SHALL have parameter NB_COUNTERS, default 8, the number of counter channels (legal 1..8).
REQ-003 SHALL have parameter NB_EVENTS, default 8, the width of the event vector (legal 1..256).
REQ-004 SHALL have parameter COUNTER_WIDTH, default 48, the counter width (legal 32..64).
REQ-005 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port start, input, 1, CI start strobe.
REQ-008 SHALL have port ciN, input, 8, CI number.
REQ-009 SHALL have port valueA, input, 32, the command word: [3:0] opcode, [4] shadow-read select.
REQ-010 SHALL have port valueB, input, 32, the command operand.
REQ-011 SHALL have port events, input, NB_EVENTS, per-cycle event qualifiers (bit0 tied 1 = CPU cycles, bit1 stall, bit2 busIdle by convention).
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port result, output, 32, returned data; 0 whenever done=0.

Function
REQ-014 SHALL accept a command only when start=1 and ciN==customId; all other cycles are ignored.
REQ-015 SHALL assert done, registered, exactly one cycle after the accepting cycle; back-to-back accepted starts each produce one done pulse.
REQ-016 SHALL decode opcode 0 READ_LO: result = bits [31:0] of counter valueB[2:0] (live, or the shadow copy when valueA[4]=1).
REQ-017 SHALL decode opcode 1 READ_HI: result = bits [COUNTER_WIDTH-1:32] of the selected counter, zero-extended.
REQ-018 SHALL decode opcode 2 CONTROL: valueB[7:0] is the enable-set mask, [15:8] the disable mask and [23:16] the clear mask, each per channel.
REQ-019 SHALL decode opcode 3 SELECT: the event source of channel valueB[2:0] becomes valueB[15:8]; an index >= NB_EVENTS selects a constant 0 (never counts).
REQ-020 SHALL decode opcode 4 SNAPSHOT: all live counters are copied into the shadow registers in the same edge.
REQ-021 SHALL decode opcode 5 STATUS: result = {16'b0, overflow[7:0], enable[7:0]}; valueB[7:0] clears the masked overflow flags.
REQ-022 SHALL return result 0 with a normal done pulse for opcodes 6..15 and for channel indices >= NB_COUNTERS, with no state change.
REQ-023 SHALL increment channel i by 1 on each cycle in which enable[i]=1 and events[sel[i]]=1.
REQ-024 SHALL wrap a counter at all-ones to 0 and set sticky overflow[i] in the same edge.
REQ-025 SHALL apply clear together with increment on the same edge as clear: the counter becomes 0.
REQ-026 SHALL apply enable-set together with disable for the same channel as disable.
REQ-027 SHALL apply an overflow clear together with a new overflow on the same edge as set.
REQ-028 SHALL sample READ values before the command's own CONTROL/SNAPSHOT effects on the same edge; the read returns the pre-edge value.
REQ-029 SHALL tie unused channel bits (i >= NB_COUNTERS) in the masks and status to 0.

Reset
REQ-030 SHALL on reset=0 at a clock edge set all counters, shadows, enables and overflow flags to 0, sel[i] to i mod NB_EVENTS, and done and result to 0.
REQ-031 SHALL have reset abort any pending done pulse, and have reset take precedence over every command and event.

Structure
REQ-032 SHALL place the opcode constants (OP_READ_LO..OP_STATUS) and MAX_COUNTERS=8 in shared package profile_ci_pkg.
REQ-033 SHALL implement each channel as an instance of sub-module event_counter (inputs enable, event, clear; outputs value, wrap pulse).

Verification
REQ-034 SHALL be checked by this directed scenario: CONTROL valueB=0x000001 with events[0]=1 for 100 cycles, then READ_LO ch0 -> result=100 (+/- the fixed command latency, checked exactly), done high for 1 cycle.
REQ-035 SHALL be checked by this directed scenario: SELECT ch1 event1, enable ch1, drive stall on 37 cycles -> READ_LO ch1 = 37.
REQ-036 SHALL be checked by this directed scenario: force ch2 to 2^48-1 via run, one more event -> READ_LO=0, READ_HI=0, STATUS bit 10 (overflow[2]) = 1; STATUS clear valueB=0x04 -> bit 10 = 0.
REQ-037 SHALL be checked by this directed scenario: SNAPSHOT at count 50, run 20 more cycles -> shadow READ_LO (valueA=0x10) = 50 and live READ_LO = 70.
REQ-038 SHALL be checked by this directed scenario: CONTROL valueB=0x010101 (set, disable and clear ch0 at once) -> ch0 disabled and count 0.
REQ-039 SHALL be checked by this directed scenario: ciN=customId+1 with start -> no done; reset=0 mid-count -> all reads 0 and enables 0.
